// File: rtl/booth_mac_sequencer.sv
// Feeds one operand pair at a time to the sequential Booth multiplier and accumulates its product.
// Result is valid WAIT_CYCLES+2 edges after accept; a stalled result holds in_ready low.
module booth_mac_sequencer #(
    parameter int ACC_W       = 24,
    parameter int WAIT_CYCLES = 9,
    parameter int SATURATE    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_m,
    input  logic [7:0]              in_q,
    input  logic                    in_clr,
    output logic                    mul_start,
    output logic [7:0]              mul_m,
    output logic [7:0]              mul_q,
    input  logic [15:0]             mul_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [15:0]             res_product,
    output logic [ACC_W-1:0]        res_acc,
    output logic                    acc_ovf,
    output logic                    busy
);

    localparam int CNT_W = ($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         m_q;
    logic [7:0]         q_q;
    logic               clr_q;
    logic               in_ready_q;
    logic               mul_start_q;
    logic               res_valid_q;
    logic               busy_q;
    logic [15:0]        prod_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;

    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W-1:0]   sum;
    logic               sum_ovf;
    logic [ACC_W-1:0]   acc_d;
    logic               ovf_d;

    assign p_ext   = ACC_W'($signed(mul_out));
    assign sum     = acc_q + p_ext;
    // Signed overflow: both addends share a sign that the sum does not.
    assign sum_ovf = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != p_ext[ACC_W-1]);

    always_comb begin
        acc_d = sum;
        ovf_d = ovf_q;
        if (clr_q) begin
            acc_d = p_ext;
            ovf_d = 1'b0;
        end else if (sum_ovf) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) begin
                acc_d = p_ext[ACC_W-1] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            q_q         <= '0;
            clr_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            mul_start_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        m_q         <= in_m;
                        q_q         <= in_q;
                        clr_q       <= in_clr;
                        in_ready_q  <= 1'b0;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= START;
                    end
                end
                START: begin
                    mul_start_q <= 1'b0;
                    cnt_q       <= CNT_W'(WAIT_CYCLES);
                    state_q     <= WAIT;
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        // First and only sampling point of mul_out for this operation.
                        prod_q      <= mul_out;
                        acc_q       <= acc_d;
                        ovf_q       <= ovf_d;
                        res_valid_q <= 1'b1;
                        state_q     <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign mul_start   = mul_start_q;
    assign mul_m       = m_q;
    assign mul_q       = q_q;
    assign res_valid   = res_valid_q;
    assign res_product = prod_q;
    assign res_acc     = acc_q;
    assign acc_ovf     = ovf_q;
    assign busy        = busy_q;

endmodule
